// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and round-robin pick helper for the 4-way arbiter
package mux_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    // Lowest offset from ptr wins; iterating downward lets the closest requester overwrite.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        rr_pick = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/mux_4_way_16_bit.sv
// rtl/mux_4_way_16_bit.sv - 4-way word select datapath
module mux_4_way_16_bit #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [1:0]   sel,
    output logic [W-1:0] out
);

    always_comb begin
        case (sel)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
        endcase
    end

endmodule

// File: rtl/mux_4_way_rr_arbiter.sv
// rtl/mux_4_way_rr_arbiter.sv - round-robin burst arbiter sharing one registered output channel
module mux_4_way_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [N_REQ-1:0]  req_last,
    input  logic [DATA_W-1:0] req_data_a,
    input  logic [DATA_W-1:0] req_data_b,
    input  logic [DATA_W-1:0] req_data_c,
    input  logic [DATA_W-1:0] req_data_d,
    output logic [N_REQ-1:0]  req_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [SEL_W-1:0]  out_src,
    input  logic              out_ready,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t        state;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  grant;
    logic [CNT_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] mux_out;
    logic              out_free;
    logic              xfer;
    logic              grant_end;

    mux_4_way_16_bit #(.W(DATA_W)) u_mux (
        .a   (req_data_a),
        .b   (req_data_b),
        .c   (req_data_c),
        .d   (req_data_d),
        .sel (grant),
        .out (mux_out)
    );

    // The output register can accept a beat when empty or draining this cycle.
    assign out_free = !out_valid || out_ready;

    always_comb begin
        req_ready = '0;
        if (state == ARB_GRANT && out_free) req_ready[grant] = 1'b1;
    end

    assign xfer      = req_valid[grant] & req_ready[grant];
    assign grant_end = xfer & (req_last[grant] | (beat_cnt == CNT_W'(MAX_BURST - 1)));
    assign busy      = (state == ARB_GRANT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= mux_out;
                out_src   <= grant;
                out_last  <= grant_end;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    beat_cnt <= '0;
                    if (|req_valid) begin
                        grant <= rr_pick(req_valid, rr_ptr);
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (xfer) beat_cnt <= beat_cnt + CNT_W'(1);
                    if (grant_end) begin
                        rr_ptr <= grant + SEL_W'(1);
                        state  <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4_way_rr_arbiter.sv
// tb/tb_mux_4_way_rr_arbiter.sv - scoreboard bench for the round-robin arbiter
module tb_mux_4_way_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [15:0] da = '0, db = '0, dc = '0, dd = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic [1:0]  out_src;
    logic        out_ready = 1'b1;
    logic        busy;

    mux_4_way_rr_arbiter #(.DATA_W(16), .MAX_BURST(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data_a (da),
        .req_data_b (db),
        .req_data_c (dc),
        .req_data_d (dd),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b1;
    bit          gap_chk = 1'b0;
    int          last_fire = -1;
    logic [16:0] srcq [4][$];
    logic [18:0] sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive();
        logic [16:0] h [4];
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = (srcq[i].size() > 0);
            h[i] = (srcq[i].size() > 0) ? srcq[i][0] : 17'd0;
            req_last[i] = h[i][0];
        end
        da = h[0][16:1];
        db = h[1][16:1];
        dc = h[2][16:1];
        dd = h[3][16:1];
    endtask

    task automatic send(input int r, input logic [15:0] d, input logic l);
        srcq[r].push_back({d, l});
    endtask

    task automatic exp_beat(input logic [15:0] d, input logic [1:0] s, input logic l);
        sbq.push_back({d, s, l});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        for (int i = 0; i < 4; i++) srcq[i].delete();
        sbq.delete();
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((sbq.size() != 0 || srcq[0].size() != 0 || srcq[1].size() != 0 ||
                srcq[2].size() != 0 || srcq[3].size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sbq.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Source model: pops a beat from a requester queue when it was accepted at the edge.
    initial begin
        logic [3:0] acc;
        forever begin
            @(posedge clk);
            acc = req_valid & req_ready;
            #1;
            for (int i = 0; i < 4; i++)
                if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            drive();
        end
    end

    initial begin
        logic        hold = 1'b0;
        logic [18:0] held = '0;
        logic [18:0] cur;
        logic [18:0] expd;
        forever begin
            @(negedge clk);
            cur = {out_data, out_src, out_last};
            if (rst_n && mon_en) begin
                if (hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_stable", cur, held);
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h required=none", cur);
                    end else begin
                        expd = sbq.pop_front();
                        chk("out_beat", cur, expd);
                    end
                    if (gap_chk && last_fire >= 0) chk("grant_gap", cyc - last_fire, 2);
                    last_fire = cyc;
                end
                hold = out_valid && !out_ready;
                held = cur;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // single beat latency
        send(0, 16'd12, 1'b1);
        exp_beat(16'd12, 2'd0, 1'b1);
        @(negedge clk);
        chk("sb_ready_c0", req_ready, 4'b0000);
        @(negedge clk);
        chk("sb_ready_c1", req_ready, 4'b0001);
        chk("sb_busy_c1", busy, 1);
        @(negedge clk);
        chk("sb_valid_c2", out_valid, 1);
        chk("sb_data_c2", out_data, 16'd12);
        chk("sb_last_c2", out_last, 1);
        chk("sb_busy_c2", busy, 0);
        wait_drain(20);

        // all valid single-beat rotation with one idle cycle per grant
        do_reset();
        last_fire = -1;
        gap_chk = 1'b1;
        send(0, 16'd12, 1'b1); send(0, 16'd12, 1'b1);
        send(1, 16'd15, 1'b1); send(2, 16'd10, 1'b1); send(3, 16'd8, 1'b1);
        exp_beat(16'd12, 2'd0, 1'b1); exp_beat(16'd15, 2'd1, 1'b1);
        exp_beat(16'd10, 2'd2, 1'b1); exp_beat(16'd8, 2'd3, 1'b1);
        exp_beat(16'd12, 2'd0, 1'b1);
        wait_drain(40);
        gap_chk = 1'b0;

        // burst with last on third beat
        do_reset();
        send(1, 16'h0101, 1'b0); send(1, 16'h0102, 1'b0); send(1, 16'h0103, 1'b1);
        send(2, 16'h0201, 1'b1);
        exp_beat(16'h0101, 2'd1, 1'b0); exp_beat(16'h0102, 2'd1, 1'b0);
        exp_beat(16'h0103, 2'd1, 1'b1); exp_beat(16'h0201, 2'd2, 1'b1);
        wait_drain(40);

        // beat cap forces release after 8 beats
        do_reset();
        for (int i = 1; i <= 10; i++) send(0, 16'h0C00 + 16'(i), 1'b0);
        send(3, 16'h00D1, 1'b1);
        for (int i = 1; i <= 8; i++) exp_beat(16'h0C00 + 16'(i), 2'd0, (i == 8));
        exp_beat(16'h00D1, 2'd3, 1'b1);
        exp_beat(16'h0C09, 2'd0, 1'b0); exp_beat(16'h0C0A, 2'd0, 1'b0);
        wait_drain(80);

        // backpressure holds the output stage
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(0, 16'h00B0 + 16'(i), (i == 4));
            exp_beat(16'h00B0 + 16'(i), 2'd0, (i == 4));
        end
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        chk("bp_valid_seen", out_valid, 1);
        @(posedge clk);
        #2 out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 4'b0000);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain(40);

        // reset during a burst, then fresh rotation from requester 0
        mon_en = 1'b0;
        for (int i = 1; i <= 6; i++) send(2, 16'h0E00 + 16'(i), 1'b0);
        for (int n = 0; n < 4; n++) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        do_reset();
        mon_en = 1'b1;
        send(0, 16'h0A0A, 1'b1); send(1, 16'h0B0B, 1'b1);
        send(2, 16'h0C0C, 1'b1); send(3, 16'h0D0D, 1'b1);
        exp_beat(16'h0A0A, 2'd0, 1'b1); exp_beat(16'h0B0B, 2'd1, 1'b1);
        exp_beat(16'h0C0C, 2'd2, 1'b1); exp_beat(16'h0D0D, 2'd3, 1'b1);
        wait_drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
